// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, redirect, multi-cycle MDU and data-memory wait
// arbitration into per-stage stall/flush controls, plus stall/flush event counters.
module hazard_ctrl #(
    parameter int MDU_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_is_load,
    input  logic        ex_redirect,
    input  logic        ex_mdu_start,
    input  logic        mem_wait,
    output logic        pc_stall,
    output logic [3:0]  stall,
    output logic [3:0]  flush,
    output logic        mdu_done,
    output logic [31:0] cnt_stall,
    output logic [31:0] cnt_flush
);

    localparam int CW = $clog2(MDU_LAT);
    localparam logic [CW-1:0] CNT_INIT = CW'(MDU_LAT - 2);

    typedef enum logic {RUN, BUSY} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     stall_cnt_q, flush_cnt_q;
    logic            load_use;

    assign load_use = ex_is_load && ex_reg_write && (ex_rd != 5'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (pc_stall)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush != 4'b0000)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    // NOTE: defaults at the top of each combinational block guarantee every
    // path assigns every signal, so no latches are inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                // A held EX or a squashed instruction never enters the MDU.
                if (!mem_wait && !ex_redirect && ex_mdu_start) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (!mem_wait) begin
                    if (cnt_q != '0)
                        cnt_d = cnt_q - CW'(1);
                    else
                        state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pc_stall = 1'b0;
        stall    = 4'b0000;
        flush    = 4'b0000;
        mdu_done = 1'b0;
        if (!rst) begin
            if (mem_wait) begin
                // MEM holds, so everything upstream holds and WB gets a bubble.
                pc_stall = 1'b1;
                stall    = 4'b0111;
                flush    = 4'b1000;
            end else if (state_q == BUSY) begin
                if (cnt_q != '0) begin
                    pc_stall = 1'b1;
                    stall    = 4'b0011;
                    flush    = 4'b0100;
                end else begin
                    mdu_done = 1'b1;
                end
            end else if (ex_redirect) begin
                flush = 4'b0011;
            end else if (ex_mdu_start) begin
                pc_stall = 1'b1;
                stall    = 4'b0011;
                flush    = 4'b0100;
            end else if (load_use) begin
                pc_stall = 1'b1;
                stall    = 4'b0001;
                flush    = 4'b0010;
            end
        end
    end

    assign cnt_stall = rst ? 32'd0 : stall_cnt_q;
    assign cnt_flush = rst ? 32'd0 : flush_cnt_q;

endmodule
